// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based RAW hazard detector: per-register pending-writer and pending-load
// counters plus a global in-flight count, producing a zero-latency stall for the ID stage.
module scoreboard_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_INFLIGHT   = 4,
    parameter bit FWD_EN         = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic                      issue_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] issue_waddr,
    input  logic                      wb_valid,
    input  logic                      wb_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
    input  logic                      flush,
    output logic                      PC_enable,
    output logic                      if_id_reg_enable,
    output logic                      hazard_clear_ctr,
    output logic [31:0]               stall_cycles,
    output logic                      underflow_err
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;
    localparam int CW   = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [CW-1:0] pend_cnt [NREG];
    logic [CW-1:0] load_cnt [NREG];
    logic [CW-1:0] inflight;

    logic hazard1;
    logic hazard2;
    logic full;
    logic stall;
    logic issue_fire;
    logic retire;
    logic underflow_now;

    // A retire against an empty counter is dropped; with a same-cycle issue the pair nets to zero.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic inc,
                                               input logic dec);
        if (dec && cnt == '0) return '0;
        return cnt + CW'(inc) - CW'(dec);
    endfunction

    assign hazard1 = id_rs1_used && (id_rs1 != '0) &&
                     (FWD_EN ? (load_cnt[id_rs1] != '0) : (pend_cnt[id_rs1] != '0));
    assign hazard2 = id_rs2_used && (id_rs2 != '0) &&
                     (FWD_EN ? (load_cnt[id_rs2] != '0) : (pend_cnt[id_rs2] != '0));
    assign full    = (inflight == CNT_MAX) && issue_valid && issue_wen;
    assign stall   = issue_valid && (hazard1 || hazard2 || full);

    assign PC_enable        = !stall;
    assign if_id_reg_enable = !stall;
    assign hazard_clear_ctr = stall;

    assign issue_fire = issue_valid && !stall && issue_wen && (issue_waddr != '0) && !flush;
    assign retire     = wb_valid && (wb_waddr != '0) && !flush;

    assign underflow_now = retire && ((pend_cnt[wb_waddr] == '0) ||
                                      (wb_is_load && load_cnt[wb_waddr] == '0) ||
                                      (inflight == '0));

    // Register 0 gets a counter pair like the rest but issue_fire/retire never target it.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic issue_hit;
            logic retire_hit;
            assign issue_hit  = issue_fire && (issue_waddr == REG_ADDR_WIDTH'(gi));
            assign retire_hit = retire && (wb_waddr == REG_ADDR_WIDTH'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_cnt[gi] <= '0;
                    load_cnt[gi] <= '0;
                end else if (flush) begin
                    pend_cnt[gi] <= '0;
                    load_cnt[gi] <= '0;
                end else begin
                    pend_cnt[gi] <= cnt_next(pend_cnt[gi], issue_hit, retire_hit);
                    load_cnt[gi] <= cnt_next(load_cnt[gi], issue_hit && issue_is_load,
                                             retire_hit && wb_is_load);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else begin
            inflight <= cnt_next(inflight, issue_fire, retire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (underflow_now) underflow_err <= 1'b1;
        end
    end
endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, 5, register address width.
REQ-002 SHALL have parameter MAX_INFLIGHT, 4, maximum issued-but-unretired writers; power of two, 2..16.
REQ-003 SHALL have parameter FWD_EN, 1, 1: stall only on pending loads; 0: stall on any pending write.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port id_rs1, id_rs2  input  REG_ADDR_WIDTH each  ID-stage source registers.
REQ-007 SHALL have port id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-008 SHALL have port issue_valid  input  1  ID instruction requests advance to EX.
REQ-009 SHALL have port issue_wen, issue_is_load  input  1 each  instruction writes rd; is a load.
REQ-010 SHALL have port issue_waddr  input  REG_ADDR_WIDTH  destination register.
REQ-011 SHALL have port wb_valid, wb_is_load  input  1 each  writer retires this cycle; was a load.
REQ-012 SHALL have port wb_waddr  input  REG_ADDR_WIDTH  retiring destination.
REQ-013 SHALL have port flush  input  1  synchronous pipeline flush; discards all in-flight writers.
REQ-014 SHALL have ports PC_enable, if_id_reg_enable  output  1 each  low while stalled.
REQ-015 SHALL have port hazard_clear_ctr  output  1  bubble insertion into ID/EX, high while stalled.
REQ-016 SHALL have ports stall_cycles  output  32, underflow_err  output  1.

Function
REQ-017 SHALL keep per-register counters pend_cnt[r], load_cnt[r] (width log2(MAX_INFLIGHT)+1) and global inflight counter, registers 1..2^REG_ADDR_WIDTH-1; register 0 never tracked.
REQ-018 SHALL form hazard = id_rsN_used && id_rsN!=0 && (FWD_EN ? load_cnt[id_rsN]!=0 : pend_cnt[id_rsN]!=0), for N=1,2, using registered counts only (no same-cycle WB bypass).
REQ-019 SHALL form full = (inflight == MAX_INFLIGHT) && issue_valid && issue_wen.
REQ-020 SHALL set stall = issue_valid && (hazard || full); PC_enable = if_id_reg_enable = !stall; hazard_clear_ctr = stall; all combinational, zero latency.
REQ-021 SHALL define issue_fire = issue_valid && !stall && issue_wen && issue_waddr!=0 && !flush.
REQ-022 SHALL define retire = wb_valid && wb_waddr!=0 && !flush.
REQ-023 On issue_fire SHALL increment pend_cnt[issue_waddr], load_cnt if issue_is_load, and inflight at next clk edge.
REQ-024 On retire SHALL decrement pend_cnt[wb_waddr], load_cnt if wb_is_load, and inflight.
REQ-025 Issue and retire in the same cycle (same or different register) SHALL both apply; same register, same type nets zero change.
REQ-026 A retire whose counter is already 0 SHALL leave it 0 and set underflow_err (sticky until reset).
REQ-027 flush SHALL zero every counter and inflight at next edge, overriding simultaneous issue/retire; stall outputs that cycle still follow REQ-020.
REQ-028 stall_cycles SHALL increment each cycle stall is 1, saturate at 0xFFFFFFFF, unaffected by flush.

Reset
REQ-029 rst_n low SHALL immediately clear all counters, inflight, stall_cycles, underflow_err; outputs then PC_enable=1, if_id_reg_enable=1, hazard_clear_ctr=0.
REQ-030 Reset asserted mid-stall SHALL release the stall asynchronously; first edge after rst_n rises SHALL accept issue normally.

Verification
REQ-031 FWD_EN=1: issue load x5, next cycle id_rs1=5 used -> stall=1, stall_cycles=1; wb load x5 -> stall=0 following cycle.
REQ-032 FWD_EN=1: issue ALU write x6, then id_rs2=6 -> no stall; FWD_EN=0 same stimulus -> stall until wb x6.
REQ-033 MAX_INFLIGHT=4: four writers to x1..x4 unretired, fifth issue -> stall; retire x1 -> fifth issues next cycle, inflight=4.
REQ-034 Issue x7 and retire x7 same cycle with pend_cnt[7]=1 -> pend_cnt[7] remains 1; rs1=0 used after load to x0 -> never stalls.
REQ-035 Three loads pending, flush -> all counters 0 next cycle, no stall; subsequent wb x3 -> underflow_err=1.
REQ-036 rst_n pulsed low while stalled -> PC_enable=1 without clock edge, stall_cycles=0.
